sd_sector_client: RTL and testbench
===================================

SD_SECTOR_CLIENT -- requirements
Module: sd_sector_client

Interface
REQ-001 The block SHALL have parameter SRC, default 0, giving the request bit (0..7) this client drives on the 8-bit start buses.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 24'd10000000, giving the watchdog limit in clk cycles.
REQ-003 The ports SHALL be:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_rd  in  1  one-cycle pulse; read sector req_lba into the local buffer.
- req_wr  in  1  one-cycle pulse; write the local buffer to sector req_lba.
- req_lba  in  32  sector number, sampled with the request pulse.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- err  out  1  sticky error flag, cleared by the next accepted request.
- buf_addr  in  9  core port address into the 512-byte buffer.
- buf_din  in  8  core port write data.
- buf_we  in  1  core port write enable.
- buf_dout  out  8  core port read data, registered, 1-cycle latency.
- rstart  out  8  per-source read start to sd_card.
- wstart  out  8  per-source write start to sd_card.
- rsector  out  32  latched sector number to sd_card.
- rbusy  in  1  sd_card busy.
- rdone  in  1  sd_card completion pulse.
- outen  in  1  sector byte valid from sd_card.
- outaddr  in  9  sector byte index from sd_card.
- outbyte  in  8  sector byte from sd_card.
- inbyte  out  8  write data to sd_card.

Function
REQ-004 The local buffer SHALL be a 512x8 dual-port RAM. Port A serves sd_card: it is written at outaddr when outen=1 in RD_XFER and is read at outaddr otherwise. Port B serves the core.
REQ-005 inbyte SHALL equal buffer[outaddr] as sampled one clk earlier (1-cycle registered latency).
REQ-006 The FSM SHALL have the states IDLE, RD_XFER, WR_XFER and FINISH.
REQ-007 In IDLE, req_rd SHALL latch req_lba into rsector, clear err and the byte counter, and enter RD_XFER on the next cycle.
REQ-008 In IDLE, req_wr (with req_rd=0) SHALL do the same and enter WR_XFER.
REQ-009 If req_rd and req_wr are asserted together, req_rd SHALL win and req_wr SHALL be dropped.
REQ-010 Requests SHALL be ignored while busy=1.
REQ-011 In RD_XFER, rstart[SRC] SHALL be held at 1. In WR_XFER, wstart[SRC] SHALL be held at 1. All other bits SHALL be 0.
REQ-012 The start bit SHALL stay asserted until the cycle rdone=1 is sampled, then deassert on the next edge as the FSM enters FINISH.
REQ-013 In RD_XFER, a 10-bit counter SHALL increment on each outen. At rdone, a count other than 512 SHALL set err.
REQ-014 FINISH SHALL last exactly one cycle, pulse done=1, and return to IDLE.
REQ-015 busy SHALL be 1 in RD_XFER, WR_XFER and FINISH. Request-to-busy latency SHALL be 1 cycle.
REQ-016 buf_we SHALL be ignored while busy=1. Core reads SHALL be allowed at any time.
REQ-017 rdone or outen seen in IDLE SHALL be ignored and SHALL write nothing.
REQ-018 rbusy SHALL be informational only and SHALL NOT gate FSM transitions.

Reset
REQ-019 While rst=1, the block SHALL force: state=IDLE, rstart=0, wstart=0, rsector=0, busy=0, done=0, err=0, byte counter=0, watchdog=0.
REQ-020 buf_dout, inbyte and the RAM contents SHALL NOT be reset.
REQ-021 Reset mid-transfer SHALL drop the start bit on the next edge and SHALL NOT pulse done.

Configuration
REQ-022 With macro SD_SECTOR_CLIENT_TIMEOUT_EN defined, a 24-bit watchdog SHALL clear on entry to RD_XFER or WR_XFER and increment every cycle in those states.
REQ-023 When the watchdog reaches TIMEOUT_CYCLES without rdone, the block SHALL set err, deassert the start bit, and enter FINISH (done pulses).
REQ-024 Without SD_SECTOR_CLIENT_TIMEOUT_EN, there SHALL be no watchdog logic, and the block SHALL wait for rdone indefinitely.

Verification
REQ-025 Read: SRC=2, req_rd with req_lba=32'h00001234. Model streams 512 outen bytes (value = addr[7:0]), then rdone. Required: rsector=32'h1234; rstart=8'h04 until rdone; done pulse; err=0; buf_dout at addr 9'h1FF = 8'hFF.
REQ-026 Write: core fills buffer[n]=n^8'h5A, then req_wr with req_lba=7. Model steps outaddr 0..511. Required: wstart=8'h04; each inbyte matches one cycle later; buf_we during busy leaves the RAM unchanged.
REQ-027 Short read: 100 outen bytes, then rdone. Required: done pulses and err=1; the next req_rd clears err.
REQ-028 Collision: req_rd and req_wr in the same cycle, plus a second req_rd while busy. Required: only rstart[SRC] asserts, rsector keeps the first LBA, and exactly one done pulse occurs.
REQ-029 Reset: rst asserted at byte 200 of a read. Required: rstart=0 the next cycle, busy=0, no done pulse; a following read completes normally.
REQ-030 Timeout (macro defined, TIMEOUT_CYCLES=1000, rdone never sent): required start deassert and done pulse 1000 cycles after entering the transfer state, with err=1.

Source files
------------

// File: rtl/sd_sector_client.sv
// Sector client for sd_card: a 512-byte dual-port buffer and a read/write request FSM.
// Optional watchdog enabled by defining SD_SECTOR_CLIENT_TIMEOUT_EN.
module sd_sector_client #(
  parameter int          SRC            = 0,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_lba,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_din,
  input  logic        buf_we,
  output logic [7:0]  buf_dout,
  output logic [7:0]  rstart,
  output logic [7:0]  wstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  output logic [7:0]  inbyte
);

  typedef enum logic [1:0] {IDLE, RD_XFER, WR_XFER, FINISH} state_t;

  localparam logic [7:0] SRC_MASK = 8'h01 << SRC;

  state_t      state_q, state_d;
  logic [31:0] rsector_q, rsector_d;
  logic        err_q, err_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  mem [512];
  logic [7:0]  buf_dout_q, inbyte_q;

  // rbusy is status only; TIMEOUT_CYCLES is consumed only by the watchdog build
  logic unused_ok;
  assign unused_ok = ^{rbusy, TIMEOUT_CYCLES};

  // Port A writes only while reading (busy), port B only while idle: never both.
  always_ff @(posedge clk) begin
    if (state_q == RD_XFER && outen) mem[outaddr] <= outbyte;
    if (state_q == IDLE && buf_we)   mem[buf_addr] <= buf_din;
    inbyte_q   <= mem[outaddr];
    buf_dout_q <= mem[buf_addr];
  end

`ifdef SD_SECTOR_CLIENT_TIMEOUT_EN
  logic [23:0] wdog_q, wdog_d, wdog_inc;
  logic        timeout;
  assign wdog_inc = wdog_q + 24'd1;
  assign timeout  = (state_q == RD_XFER || state_q == WR_XFER) && (wdog_inc >= TIMEOUT_CYCLES);

  always_comb begin
    wdog_d = 24'd0;
    if (state_q == RD_XFER || state_q == WR_XFER) wdog_d = wdog_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= 24'd0;
    else     wdog_q <= wdog_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    rsector_d = rsector_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_rd || req_wr) begin
          state_d   = req_rd ? RD_XFER : WR_XFER;
          rsector_d = req_lba;
          err_d     = 1'b0;
          cnt_d     = 10'd0;
        end
      end
      RD_XFER: begin
        if (outen) cnt_d = cnt_q + 10'd1;
        if (rdone) begin
          state_d = FINISH;
          if (cnt_d != 10'd512) err_d = 1'b1;
        end
      end
      WR_XFER: if (rdone) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef SD_SECTOR_CLIENT_TIMEOUT_EN
    if (timeout && !rdone) begin
      state_d = FINISH;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rsector_q <= 32'd0;
      err_q     <= 1'b0;
      cnt_q     <= 10'd0;
    end else begin
      state_q   <= state_d;
      rsector_q <= rsector_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign err      = err_q;
  assign rstart   = (state_q == RD_XFER) ? SRC_MASK : 8'h00;
  assign wstart   = (state_q == WR_XFER) ? SRC_MASK : 8'h00;
  assign rsector  = rsector_q;
  assign buf_dout = buf_dout_q;
  assign inbyte   = inbyte_q;

endmodule

// File: tb/tb_sd_sector_client.sv
// Directed bench for sd_sector_client (SRC=2) with a simple sd_card stand-in.
module tb_sd_sector_client;
  logic        clk = 1'b0;
  logic        rst, req_rd, req_wr, buf_we, rbusy, rdone, outen;
  logic [31:0] req_lba;
  logic [8:0]  buf_addr, outaddr;
  logic [7:0]  buf_din, outbyte;
  logic        busy, done, err;
  logic [7:0]  buf_dout, rstart, wstart, inbyte;
  logic [31:0] rsector;

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, wst_cnt = 0;

  sd_sector_client #(.SRC(2), .TIMEOUT_CYCLES(24'd1000)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .busy(busy), .done(done), .err(err), .buf_addr(buf_addr), .buf_din(buf_din),
    .buf_we(buf_we), .buf_dout(buf_dout), .rstart(rstart), .wstart(wstart),
    .rsector(rsector), .rbusy(rbusy), .rdone(rdone), .outen(outen),
    .outaddr(outaddr), .outbyte(outbyte), .inbyte(inbyte)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wstart != 8'h00) wst_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n outen bytes with value addr^xr, then one rdone cycle; returns stuck-start cycles.
  task automatic stream_rd(input int n, input logic [7:0] xr, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (rstart !== 8'h04) bad++;
      outen = 1'b1; outaddr = 9'(i); outbyte = 8'(i) ^ xr;
      tick();
    end
    outen = 1'b0;
    if (rstart !== 8'h04) bad++;
    rdone = 1'b1;
    tick();
    rdone = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] lba);
    req_rd = rd; req_wr = wr; req_lba = lba;
    tick();
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  int bad, d0, w0, cyc;
  logic [7:0] e8;

  initial begin
    rst = 1'b1; req_rd = 0; req_wr = 0; req_lba = 0; buf_we = 0; buf_addr = 0;
    buf_din = 0; rbusy = 0; rdone = 0; outen = 0; outaddr = 0; outbyte = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_start", {rstart, wstart}, 0);
    chk("rst_sector", rsector, 0);
    rst = 1'b0;
    tick();

    // Full read
    req(1, 0, 32'h00001234);
    chk("rd_busy", busy, 1);
    chk("rd_sector", rsector, 32'h1234);
    chk("rd_rstart", rstart, 8'h04);
    stream_rd(512, 8'h00, bad);
    chk("rd_start_held", bad, 0);
    chk("rd_done", done, 1);
    chk("rd_start_drop", rstart, 0);
    chk("rd_err", err, 0);
    tick();
    chk("rd_idle", {busy, done}, 0);
    buf_addr = 9'h1FF; tick();
    chk("rd_buf_1ff", buf_dout, 8'hFF);
    buf_addr = 9'h037; tick();
    chk("rd_buf_037", buf_dout, 8'h37);

    // Core fill then write transfer; core writes during busy must be dropped
    for (int i = 0; i < 512; i++) begin
      buf_we = 1'b1; buf_addr = 9'(i); buf_din = 8'(i) ^ 8'h5A;
      tick();
    end
    buf_we = 1'b0;
    req(0, 1, 32'd7);
    chk("wr_wstart", wstart, 8'h04);
    chk("wr_rstart", rstart, 8'h00);
    chk("wr_sector", rsector, 32'd7);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      outaddr = 9'(i);
      buf_we = 1'b1; buf_addr = 9'(i); buf_din = 8'h00;
      tick();
      e8 = 8'(i) ^ 8'h5A;
      if (inbyte !== e8) bad++;
    end
    buf_we = 1'b0;
    chk("wr_inbyte", bad, 0);
    rdone = 1'b1; tick(); rdone = 1'b0;
    chk("wr_done", done, 1);
    chk("wr_err", err, 0);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      buf_addr = 9'(i); tick();
      e8 = 8'(i) ^ 8'h5A;
      if (buf_dout !== e8) bad++;
    end
    chk("wr_ram_kept", bad, 0);

    // Short read sets err, which is sticky until the next request
    req(1, 0, 32'd55);
    stream_rd(100, 8'hC0, bad);
    chk("short_done", done, 1);
    chk("short_err", err, 1);
    tick();
    chk("short_err_sticky", err, 1);

    // Collision: rd+wr together, then another rd while busy
    d0 = done_cnt; w0 = wst_cnt;
    req(1, 1, 32'hAAAA0001);
    chk("col_err_clr", err, 0);
    chk("col_rstart", rstart, 8'h04);
    req(1, 0, 32'hBBBB0002);
    chk("col_sector", rsector, 32'hAAAA0001);
    stream_rd(511, 8'h00, bad);
    chk("col_err_511", err, 1);
    tick(); tick(); tick();
    chk("col_one_done", done_cnt - d0, 1);
    chk("col_no_wstart", wst_cnt - w0, 0);

    // Reset at byte 200 of a read
    d0 = done_cnt;
    req(1, 0, 32'h99);
    for (int i = 0; i < 200; i++) begin
      outen = 1'b1; outaddr = 9'(i); outbyte = 8'h11;
      tick();
    end
    rst = 1'b1; tick(); outen = 1'b0;
    chk("mid_rst_start", rstart, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    tick(); tick();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    req(1, 0, 32'h42);
    stream_rd(512, 8'h33, bad);
    chk("post_rst_done", {done, err}, 2'b10);
    chk("post_rst_sector", rsector, 32'h42);
    tick();

    // Stray sd_card activity while idle
    outen = 1'b1; outaddr = 9'd5; outbyte = 8'hEE; rdone = 1'b1;
    tick();
    outen = 1'b0; rdone = 1'b0;
    chk("idle_stray", {busy, done}, 0);
    buf_addr = 9'd5; tick();
    chk("idle_no_write", buf_dout, 8'h36);

`ifdef SD_SECTOR_CLIENT_TIMEOUT_EN
    req(1, 0, 32'h77);
    cyc = 0;
    while (rstart != 8'h00 && cyc < 2000) begin
      cyc++;
      tick();
    end
    chk("to_cycles", cyc, 1000);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
